// File: rtl/web2_web.sv
// Wake event block: per-line polarity/edge qualification into sticky pending bits,
// debounced wake request FSM toward the PMU. Optional ack timeout: WEB2_WAKE_TIMEOUT_EN.
module web2_web #(
    parameter int NUM_INPUTS     = 64,
    parameter int DEBOUNCE_W     = 4,
    parameter int CNT_W          = 16
`ifdef WEB2_WAKE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clkclk,
    input  logic                  sysreset_n,
    input  logic [NUM_INPUTS-1:0] int_in,
    input  logic [NUM_INPUTS-1:0] input_invert,
    input  logic [NUM_INPUTS-1:0] edge_mode,
    input  logic [NUM_INPUTS-1:0] wake_enable,
    input  logic [NUM_INPUTS-1:0] pending_clr,
    input  logic                  event_suppress,
    input  logic                  wake_now,
    input  logic [DEBOUNCE_W-1:0] debounce_cycles,
    input  logic                  wake_ack,
    input  logic                  count_clr,
    output logic [NUM_INPUTS-1:0] pending,
    output logic [NUM_INPUTS-1:0] int_out,
    output logic                  wake,
    output logic [1:0]            wake_state,
    output logic [CNT_W-1:0]      wake_count,
    output logic                  wake_timeout
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_WAKE     = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    logic [NUM_INPUTS-1:0] r_in_q;
    logic [NUM_INPUTS-1:0] r_in_prev;
    logic [NUM_INPUTS-1:0] r_pending;
    logic [NUM_INPUTS-1:0] w_trig;
    logic                  w_req;
    logic                  w_tmo_hit;
    logic                  w_enter_wake;
    state_t                r_state;
    state_t                w_next_state;
    logic [DEBOUNCE_W-1:0] r_cnt;
    logic [DEBOUNCE_W-1:0] w_next_cnt;
    logic                  r_wake;
    logic [CNT_W-1:0]      r_count;

    always_comb begin
        w_trig = (edge_mode & r_in_q & ~r_in_prev) | (~edge_mode & r_in_q);
        w_req  = (|(r_pending & wake_enable)) | wake_now;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (debounce_cycles == '0) begin
                        w_next_state = S_WAKE;
                    end else begin
                        w_next_state = S_DEBOUNCE;
                        w_next_cnt   = debounce_cycles;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (!w_req) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == DEBOUNCE_W'(1)) begin
                    w_next_state = S_WAKE;
                end else begin
                    w_next_cnt = r_cnt - DEBOUNCE_W'(1);
                end
            end
            S_WAKE: begin
                // Request dropping is ignored here: only ack (or timeout) ends a wake.
                if (wake_ack || w_tmo_hit) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_req) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_wake = (w_next_state == S_WAKE) && (r_state != S_WAKE);

    always_ff @(posedge clkclk) begin
        if (!sysreset_n) begin
            r_in_q    <= '0;
            r_in_prev <= '0;
            r_pending <= '0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wake    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_in_q    <= int_in ^ input_invert;
            r_in_prev <= r_in_q;
            r_pending <= w_trig | (r_pending & ~pending_clr);
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_wake    <= (w_next_state == S_WAKE);
            if (count_clr) begin
                r_count <= '0;
            end else if (w_enter_wake && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

`ifdef WEB2_WAKE_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0] r_tmr;
    logic             r_timeout;

    assign w_tmo_hit = (r_state == S_WAKE) && (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clkclk) begin
        if (!sysreset_n) begin
            r_tmr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_enter_wake) begin
                r_tmr <= '0;
            end else if (r_state == S_WAKE) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end
            if (count_clr) begin
                r_timeout <= 1'b0;
            end else if (w_tmo_hit && !wake_ack) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign wake_timeout = r_timeout;
`else
    assign w_tmo_hit    = 1'b0;
    assign wake_timeout = 1'b0;
`endif

    assign pending    = r_pending;
    assign int_out    = r_pending & ~{NUM_INPUTS{event_suppress}};
    assign wake       = r_wake;
    assign wake_state = r_state;
    assign wake_count = r_count;

endmodule

// File: tb/tb_web2_web.sv
// Bench for web2_web: directed scenarios plus randomized traffic, every cycle
// compared against a rule-level reference model of the wake event block.
module tb_web2_web;

    localparam int N  = 64;
    localparam int DW = 4;
    localparam int CW = 4;
    localparam int T  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clkclk = 1'b0;
    logic          sysreset_n;
    logic [N-1:0]  int_in, input_invert, edge_mode, wake_enable, pending_clr;
    logic          event_suppress, wake_now, wake_ack, count_clr;
    logic [DW-1:0] debounce_cycles;
    logic [N-1:0]  pending, int_out;
    logic          wake, wake_timeout;
    logic [1:0]    wake_state;
    logic [CW-1:0] wake_count;

    web2_web #(
        .NUM_INPUTS(N), .DEBOUNCE_W(DW), .CNT_W(CW)
`ifdef WEB2_WAKE_TIMEOUT_EN
        , .TIMEOUT_CYCLES(T)
`endif
    ) dut (
        .clkclk(clkclk), .sysreset_n(sysreset_n), .int_in(int_in),
        .input_invert(input_invert), .edge_mode(edge_mode), .wake_enable(wake_enable),
        .pending_clr(pending_clr), .event_suppress(event_suppress), .wake_now(wake_now),
        .debounce_cycles(debounce_cycles), .wake_ack(wake_ack), .count_clr(count_clr),
        .pending(pending), .int_out(int_out), .wake(wake), .wake_state(wake_state),
        .wake_count(wake_count), .wake_timeout(wake_timeout)
    );

    always #5 clkclk = ~clkclk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model state: named phases, plain integers.
    logic [N-1:0] m_inq = '0, m_prev = '0, m_pend = '0;
    int m_phase = 0;     // 0 idle, 1 qualifying, 2 waking, 3 draining
    int m_left = 0;      // qualification cycles remaining
    int m_in_wake = 0;   // cycles spent waking so far
    int m_count = 0;
    bit m_to = 1'b0;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pending"}, pending, m_pend);
        check({tag, ".int_out"}, int_out, m_pend & ~{N{event_suppress}});
        check({tag, ".wake"}, N'(wake), N'(m_phase == 2));
        check({tag, ".state"}, N'(wake_state), N'(m_phase));
        check({tag, ".count"}, N'(wake_count), N'(m_count));
        check({tag, ".timeout"}, N'(wake_timeout), N'(m_to));
    endtask

    task automatic model_step();
        logic [N-1:0] trig;
        bit req, timed_out, entered;
        int nxt;
        if (!sysreset_n) begin
            m_inq = '0; m_prev = '0; m_pend = '0;
            m_phase = 0; m_left = 0; m_in_wake = 0; m_count = 0; m_to = 1'b0;
            return;
        end
        trig = 0;
        for (int i = 0; i < N; i++)
            trig[i] = edge_mode[i] ? (m_inq[i] && !m_prev[i]) : m_inq[i];
        req = ((m_pend & wake_enable) != 0) || wake_now;
        nxt = m_phase;
        timed_out = 1'b0;
        if (m_phase == 0 && req) begin
            if (debounce_cycles == 0) nxt = 2;
            else begin nxt = 1; m_left = int'(debounce_cycles); end
        end else if (m_phase == 1) begin
            if (!req) nxt = 0;
            else if (m_left == 1) nxt = 2;
            else m_left = m_left - 1;
        end else if (m_phase == 2) begin
            if (wake_ack) nxt = 3;
`ifdef WEB2_WAKE_TIMEOUT_EN
            else if (m_in_wake + 1 >= T) begin nxt = 3; timed_out = 1'b1; end
`endif
        end else if (m_phase == 3 && !req) begin
            nxt = 0;
        end
        entered = (nxt == 2) && (m_phase != 2);
        if (count_clr) m_count = 0;
        else if (entered && m_count < CMAX) m_count = m_count + 1;
        if (count_clr) m_to = 1'b0;
        else if (timed_out) m_to = 1'b1;
        m_in_wake = entered ? 0 : (m_phase == 2 ? m_in_wake + 1 : m_in_wake);
        m_phase = nxt;
        m_pend = trig | (m_pend & ~pending_clr);
        m_prev = m_inq;
        m_inq = int_in ^ input_invert;
    endtask

    task automatic step(input string tag);
        @(posedge clkclk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sysreset_n = 1'b0; int_in = '0; input_invert = '0; edge_mode = '0;
        wake_enable = '0; pending_clr = '0; event_suppress = 1'b0; wake_now = 1'b0;
        debounce_cycles = '0; wake_ack = 1'b0; count_clr = 1'b0;
        @(posedge clkclk); model_step();
        step("reset");
        check("reset_wake", N'(wake), '0);
        check("reset_state", N'(wake_state), '0);
        check("reset_pending", pending, '0);
        sysreset_n = 1'b1;
        step("idle");

        // Level trigger through inversion, no debounce.
        input_invert[5] = 1'b1; wake_enable[5] = 1'b1;
        step("lvl_e1");
        step("lvl_e2");
        check("lvl_pend5", N'(pending[5]), N'(1));
        check("lvl_nowake_e2", N'(wake), N'(0));
        step("lvl_e3");
        check("lvl_wake_e3", N'(wake), N'(1));
        check("lvl_count", N'(wake_count), N'(1));
        wake_ack = 1'b1;
        step("lvl_ack");
        check("lvl_drain", N'(wake_state), N'(3));
        check("lvl_wake_off", N'(wake), N'(0));
        wake_ack = 1'b0; input_invert[5] = 1'b0; pending_clr[5] = 1'b1;
        step("lvl_clrA");
        check("lvl_still_drain", N'(wake_state), N'(3));
        step("lvl_clrB");
        check("lvl_pend_clr", N'(pending[5]), N'(0));
        pending_clr[5] = 1'b0;
        step("lvl_idle");
        check("lvl_idle_state", N'(wake_state), N'(0));
        wake_enable[5] = 1'b0;

        // Edge trigger with a coincident clear: set wins.
        edge_mode[63] = 1'b1; int_in[63] = 1'b1;
        step("edge_e1");
        int_in[63] = 1'b0; pending_clr[63] = 1'b1;
        step("edge_e2");
        check("edge_set_wins", N'(pending[63]), N'(1));
        pending_clr[63] = 1'b0;
        step("edge_hold");
        event_suppress = 1'b1;
        #1;
        check("suppress_int_out", N'(int_out[63]), N'(0));
        check("suppress_pending", N'(pending[63]), N'(1));
        step("suppress");
        event_suppress = 1'b0; pending_clr[63] = 1'b1;
        step("edge_clr");
        pending_clr[63] = 1'b0; edge_mode[63] = 1'b0;

        // Debounce: short request aborts, long one wakes.
        debounce_cycles = 4'd4; wake_now = 1'b1;
        repeat (3) step("deb_short");
        check("deb_qualifying", N'(wake_state), N'(1));
        wake_now = 1'b0;
        step("deb_abort");
        check("deb_abort_idle", N'(wake_state), N'(0));
        wake_now = 1'b1;
        repeat (4) begin
            step("deb_long");
            check("deb_not_yet", N'(wake), N'(0));
        end
        step("deb_long5");
        check("deb_wake", N'(wake), N'(1));
        wake_now = 1'b0;
        step("deb_hold");
        check("deb_hold_wake", N'(wake), N'(1));
        wake_ack = 1'b1; step("deb_ack");
        wake_ack = 1'b0; step("deb_idle");

        // Counter saturation and clear priority.
        debounce_cycles = '0;
        repeat (CMAX + 1) begin
            wake_now = 1'b1; step("sat_enter");
            wake_now = 1'b0; wake_ack = 1'b1; step("sat_ack");
            wake_ack = 1'b0; step("sat_idle");
        end
        check("sat_count", N'(wake_count), N'(CMAX));
        wake_now = 1'b1; count_clr = 1'b1;
        step("clr_vs_entry");
        check("clr_priority", N'(wake_count), N'(0));
        check("clr_entry_wake", N'(wake), N'(1));
        count_clr = 1'b0; wake_now = 1'b0;

`ifdef WEB2_WAKE_TIMEOUT_EN
        repeat (T - 1) step("tmo_wait");
        check("tmo_before", N'(wake), N'(1));
        step("tmo_fire");
        check("tmo_wake_drop", N'(wake), N'(0));
        check("tmo_flag", N'(wake_timeout), N'(1));
        count_clr = 1'b1; step("tmo_clr"); count_clr = 1'b0;
        step("tmo_idle");
        wake_now = 1'b1; step("tmo2_enter"); wake_now = 1'b0;
        repeat (T - 2) step("tmo2_wait");
        wake_ack = 1'b1; step("tmo2_ack"); wake_ack = 1'b0;
        check("tmo_ack_wins", N'(wake_timeout), N'(0));
        check("tmo_ack_drain", N'(wake_state), N'(3));
`else
        repeat (3 * T) step("hold_no_ack");
        check("hold_wake", N'(wake), N'(1));
        check("hold_no_timeout", N'(wake_timeout), N'(0));
        wake_ack = 1'b1; step("hold_ack"); wake_ack = 1'b0;
`endif
        step("pre_rand");

        // Randomized traffic against the model.
        input_invert = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
        repeat (1500) begin
            int_in = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            edge_mode = {$urandom(), $urandom()};
            wake_enable = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            pending_clr = {$urandom(), $urandom()} | {$urandom(), $urandom()};
            event_suppress = ($urandom_range(0, 3) == 0);
            wake_now = ($urandom_range(0, 9) == 0);
            wake_ack = ($urandom_range(0, 3) == 0);
            count_clr = ($urandom_range(0, 63) == 0);
            debounce_cycles = DW'($urandom_range(0, 3));
            sysreset_n = ($urandom_range(0, 199) != 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
